// File: rtl/ring_router_buf.sv
// ring_router_buf: one node of a bidirectional ring NoC.
// Each input port (cw, ccw, PE) feeds its own FIFO. The FIFO head is routed by
// its hop field: hop==0 ejects to the PE, otherwise it continues in the
// direction given by the dir bit (MSB) with hop decremented. Each output has a
// registered valid/data stage and a round-robin arbiter over the inputs.
// Ports:
//   clk, reset                 clock, async active-high reset
//   cwsi/cwri/cwdi             cw input   (valid / ready / data)
//   ccwsi/ccwri/ccwdi          ccw input
//   pesi/peri/pedi             PE injection
//   cwso/cwro/cwdo             cw output  (valid / downstream ready / data)
//   ccwso/ccwro/ccwdo          ccw output
//   peso/pero/pedo             PE ejection
module ring_router_buf #(
  parameter int DW    = 64,
  parameter int HOPW  = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cwsi,
  output logic          cwri,
  input  logic [DW-1:0] cwdi,
  input  logic          ccwsi,
  output logic          ccwri,
  input  logic [DW-1:0] ccwdi,
  input  logic          pesi,
  output logic          peri,
  input  logic [DW-1:0] pedi,
  output logic          cwso,
  input  logic          cwro,
  output logic [DW-1:0] cwdo,
  output logic          ccwso,
  input  logic          ccwro,
  output logic [DW-1:0] ccwdo,
  output logic          peso,
  input  logic          pero,
  output logic [DW-1:0] pedo
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Index 0 = cw, 1 = ccw, 2 = pe for both inputs and outputs.
  logic          in_v  [3];
  logic [DW-1:0] in_d  [3];
  logic          out_r [3];

  assign in_v[0]  = cwsi;
  assign in_v[1]  = ccwsi;
  assign in_v[2]  = pesi;
  assign in_d[0]  = cwdi;
  assign in_d[1]  = ccwdi;
  assign in_d[2]  = pedi;
  assign out_r[0] = cwro;
  assign out_r[1] = ccwro;
  assign out_r[2] = pero;

  logic [DW-1:0] mem_q    [3][DEPTH];
  logic [AW-1:0] wr_ptr_q [3];
  logic [AW-1:0] wr_ptr_d [3];
  logic [AW-1:0] rd_ptr_q [3];
  logic [AW-1:0] rd_ptr_d [3];
  logic [CW-1:0] cnt_q    [3];
  logic [CW-1:0] cnt_d    [3];
  logic          push     [3];
  logic          pop      [3];

  logic [DW-1:0]   head   [3];
  logic [HOPW-1:0] hop    [3];
  logic [1:0]      tgt    [3];
  logic [DW-1:0]   routed [3];

  logic          so_q [3];
  logic          so_d [3];
  logic [DW-1:0] do_q [3];
  logic [DW-1:0] do_d [3];
  logic [1:0]    rr_q [3];
  logic [1:0]    rr_d [3];

  logic       granted;
  logic [1:0] cand;

  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Head decode: target output and the word as it leaves this node.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      head[i]   = mem_q[i][rd_ptr_q[i]];
      hop[i]    = head[i][DW-2 -: HOPW];
      routed[i] = head[i];
      tgt[i]    = 2'd2;
      if (hop[i] != '0) begin
        tgt[i] = head[i][DW-1] ? 2'd1 : 2'd0;
        routed[i][DW-2 -: HOPW] = hop[i] - HOPW'(1);
      end
    end
  end

  // Per-output arbitration. Each input targets exactly one output, so an
  // input can never be granted twice in the same cycle.
  always_comb begin
    granted = 1'b0;
    cand    = 2'd0;
    for (int i = 0; i < 3; i++) pop[i] = 1'b0;
    for (int o = 0; o < 3; o++) begin
      so_d[o] = so_q[o] && !out_r[o];
      do_d[o] = do_q[o];
      rr_d[o] = rr_q[o];
      if (!so_q[o] || out_r[o]) begin
        granted = 1'b0;
        cand    = rr_q[o];
        for (int k = 0; k < 3; k++) begin
          if (!granted && (cnt_q[cand] != '0) && (tgt[cand] == 2'(o))) begin
            granted   = 1'b1;
            pop[cand] = 1'b1;
            so_d[o]   = 1'b1;
            do_d[o]   = routed[cand];
            rr_d[o]   = rr_next(cand);
          end
          cand = rr_next(cand);
        end
      end
    end
  end

  // Ready comes only from the registered count; a same-cycle pop does not
  // make room for a push.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      push[i]     = in_v[i] && (cnt_q[i] != FULL);
      wr_ptr_d[i] = wr_ptr_q[i] + AW'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + AW'(pop[i]);
      cnt_d[i]    = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        so_q[i]     <= 1'b0;
        do_q[i]     <= '0;
        rr_q[i]     <= 2'd0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
        so_q[i]     <= so_d[i];
        do_q[i]     <= do_d[i];
        rr_q[i]     <= rr_d[i];
      end
    end
  end

  // Storage needs no reset: an empty count hides whatever it holds.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_d[i];
    end
  end

  assign cwri  = (cnt_q[0] != FULL);
  assign ccwri = (cnt_q[1] != FULL);
  assign peri  = (cnt_q[2] != FULL);
  assign cwso  = so_q[0];
  assign ccwso = so_q[1];
  assign peso  = so_q[2];
  assign cwdo  = do_q[0];
  assign ccwdo = do_q[1];
  assign pedo  = do_q[2];

endmodule

// File: tb/tb_ring_router_buf.sv
module tb_ring_router_buf;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic        vin [3];
  logic [63:0] din [3];
  logic        ro  [3];

  logic cwri, ccwri, peri, cwso, ccwso, peso;
  logic [63:0] cwdo, ccwdo, pedo;

  ring_router_buf #(.DW(64), .HOPW(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cwsi(vin[0]), .cwri(cwri), .cwdi(din[0]),
    .ccwsi(vin[1]), .ccwri(ccwri), .ccwdi(din[1]),
    .pesi(vin[2]), .peri(peri), .pedi(din[2]),
    .cwso(cwso), .cwro(ro[0]), .cwdo(cwdo),
    .ccwso(ccwso), .ccwro(ro[1]), .ccwdo(ccwdo),
    .peso(peso), .pero(ro[2]), .pedo(pedo)
  );

  initial forever #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: per-input queues, per-output valid/data, rr pointers.
  logic [63:0] m_q [3][$];
  logic        m_so [3] = '{0, 0, 0};
  logic [63:0] m_do [3] = '{0, 0, 0};
  int          m_rr [3] = '{0, 0, 0};
  bit          m_acc[3] = '{0, 0, 0};
  int msz[3];
  bit mhas[3];
  int mtg[3];
  bit mpop[3];
  int mw, mc;

  logic [63:0] lg [3][$];
  bit log_en = 0;

  int   seq  [3];
  bit   en   [3];
  logic cdir [3];
  logic [7:0] chop [3];
  bit   rnd_mode = 0;

  function automatic logic [63:0] mk(int src, logic dir, logic [7:0] hp, int s);
    return {dir, hp, 31'd0, 8'(src), 16'(s)};
  endfunction

  function automatic int tgt_of(logic [63:0] w);
    if (w[62:55] == 8'd0) return 2;
    return w[63] ? 1 : 0;
  endfunction

  function automatic logic [63:0] route(logic [63:0] w);
    logic [63:0] r;
    r = w;
    if (w[62:55] != 8'd0) r[62:55] = w[62:55] - 8'd1;
    return r;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30) $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (log_en) begin
      if (cwso && ro[0])  lg[0].push_back(cwdo);
      if (ccwso && ro[1]) lg[1].push_back(ccwdo);
      if (peso && ro[2])  lg[2].push_back(pedo);
    end
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        m_q[i].delete();
        m_so[i] = 0; m_do[i] = '0; m_rr[i] = 0; m_acc[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        msz[i]  = m_q[i].size();
        mhas[i] = (msz[i] > 0);
        mtg[i]  = mhas[i] ? tgt_of(m_q[i][0]) : -1;
        mpop[i] = 0;
      end
      for (int o = 0; o < 3; o++) begin
        if (!m_so[o] || ro[o]) begin
          mw = -1;
          for (int k = 0; k < 3; k++) begin
            mc = (m_rr[o] + k) % 3;
            if (mw < 0 && mhas[mc] && mtg[mc] == o) mw = mc;
          end
          if (mw >= 0) begin
            m_so[o] = 1;
            m_do[o] = route(m_q[mw][0]);
            mpop[mw] = 1;
            m_rr[o] = (mw + 1) % 3;
          end else begin
            m_so[o] = 0;
          end
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (mpop[i]) void'(m_q[i].pop_front());
        m_acc[i] = vin[i] && (msz[i] != DEPTH);
        if (m_acc[i]) m_q[i].push_back(din[i]);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("cwso",  cwso,  m_so[0]);
    chk("ccwso", ccwso, m_so[1]);
    chk("peso",  peso,  m_so[2]);
    chk("cwdo",  cwdo,  m_do[0]);
    chk("ccwdo", ccwdo, m_do[1]);
    chk("pedo",  pedo,  m_do[2]);
    chk("cwri",  cwri,  m_q[0].size() != DEPTH);
    chk("ccwri", ccwri, m_q[1].size() != DEPTH);
    chk("peri",  peri,  m_q[2].size() != DEPTH);
  end

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      if (vin[i] && m_acc[i]) begin
        seq[i]++;
        vin[i] = 0;
      end
      if (!vin[i] && en[i]) begin
        if (rnd_mode) begin
          cdir[i] = 1'($urandom_range(0, 1));
          chop[i] = 8'($urandom_range(0, 3));
        end
        vin[i] = 1;
        din[i] = mk(i, cdir[i], chop[i], seq[i]);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      vin[i] = 0; en[i] = 0; seq[i] = 1;
    end
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      vin[i] = 0; din[i] = '0; ro[i] = 0; en[i] = 0;
      seq[i] = 1; cdir[i] = 0; chop[i] = 8'd0;
    end

    // T1 reset
    repeat (2) @(negedge clk);
    chk("t1_cwso", cwso, 0);   chk("t1_ccwso", ccwso, 0); chk("t1_peso", peso, 0);
    chk("t1_cwdo", cwdo, 0);   chk("t1_ccwdo", ccwdo, 0); chk("t1_pedo", pedo, 0);
    chk("t1_cwri", cwri, 1);   chk("t1_ccwri", ccwri, 1); chk("t1_peri", peri, 1);
    reset = 0;

    // T2 cw forwarding
    for (int i = 0; i < 3; i++) ro[i] = 1;
    vin[0] = 1; din[0] = {1'b0, 8'd2, 55'hABCD};
    @(negedge clk); vin[0] = 0;
    @(negedge clk);
    chk("t2_cwso", cwso, 1);
    chk("t2_cwdo", cwdo, {1'b0, 8'd1, 55'hABCD});

    // T3 eject
    vin[1] = 1; din[1] = {1'b1, 8'd0, 55'h1234_5678};
    @(negedge clk); vin[1] = 0;
    @(negedge clk);
    chk("t3_peso", peso, 1);
    chk("t3_pedo", pedo, {1'b1, 8'd0, 55'h1234_5678});

    // T4 backpressure
    do_reset();
    ro[0] = 0; ro[1] = 1; ro[2] = 1;
    en[2] = 1; cdir[2] = 0; chop[2] = 8'd3;
    repeat (10) begin @(negedge clk); drive(); end
    chk("t4_peri", peri, 0);
    chk("t4_accepted", seq[2] - 1, 5);
    vin[2] = 0; en[2] = 0; ro[0] = 1;
    lg[0].delete(); log_en = 1;
    repeat (5) @(negedge clk);
    chk("t4_burst_len", lg[0].size(), 5);
    repeat (3) @(negedge clk);
    chk("t4_total_len", lg[0].size(), 5);
    for (int k = 0; k < 5; k++)
      if (lg[0].size() > k) chk("t4_word", lg[0][k], mk(2, 1'b0, 8'd2, k + 1));
    log_en = 0;

    // T5 contention on the PE output
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ro[i] = 1; en[i] = 1; cdir[i] = 0; chop[i] = 8'd0; lg[i].delete();
    end
    log_en = 1;
    repeat (6) begin @(negedge clk); drive(); end
    for (int i = 0; i < 3; i++) begin vin[i] = 0; en[i] = 0; end
    repeat (20) @(negedge clk);
    chk("t5_count_ge6", lg[2].size() >= 6, 1);
    for (int k = 0; k < 6; k++)
      if (lg[2].size() > k) chk("t5_grant", lg[2][k], mk(k % 3, 1'b0, 8'd0, k / 3 + 1));
    log_en = 0;

    // T6 mid-operation reset
    for (int i = 0; i < 3; i++) begin ro[i] = 0; en[i] = 1; chop[i] = 8'd1; end
    cdir[0] = 0; cdir[1] = 1; cdir[2] = 0;
    repeat (8) begin @(negedge clk); drive(); end
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 3; i++) begin vin[i] = 0; en[i] = 0; seq[i] = 1; end
    #1;
    chk("t6_cwso", cwso, 0); chk("t6_ccwso", ccwso, 0); chk("t6_peso", peso, 0);
    chk("t6_cwri", cwri, 1); chk("t6_ccwri", ccwri, 1); chk("t6_peri", peri, 1);
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 3; i++) begin ro[i] = 1; lg[i].delete(); end
    log_en = 1;
    vin[0] = 1; din[0] = {1'b0, 8'd1, 55'h55};
    @(negedge clk); vin[0] = 0;
    repeat (6) @(negedge clk);
    chk("t6_single", lg[0].size() + lg[1].size() + lg[2].size(), 1);
    if (lg[0].size() > 0) chk("t6_word", lg[0][0], {1'b0, 8'd0, 55'h55});
    log_en = 0;

    // Randomized traffic against the model
    rnd_mode = 1;
    repeat (3000) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        en[i] = ($urandom_range(0, 99) < 55);
        ro[i] = ($urandom_range(0, 99) < 70);
      end
      drive();
    end
    for (int i = 0; i < 3; i++) begin en[i] = 0; vin[i] = 0; ro[i] = 1; end
    repeat (40) @(negedge clk);
    chk("drain_model_empty", m_q[0].size() + m_q[1].size() + m_q[2].size(), 0);
    chk("drain_cwso", cwso, 0);
    chk("drain_ccwso", ccwso, 0);
    chk("drain_peso", peso, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
